// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: takes a word over valid/ready and emits it one bit per clock,
// with optional idle gap cycles between words and selectable bit order.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax  = CntW'(WIDTH - 1);
  localparam logic [7:0]      GapMax  = 8'(GAP) - 8'd1;
  localparam bit              NoGap   = (GAP == 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign last_bit   = (state_q == StShift) && (bit_cnt_q == '0);
  // Only a gapless last bit may overlap with the next accept.
  assign load_ready = (state_q == StIdle) || (last_bit && NoGap);
  assign accept     = load_valid && load_ready;
  assign shifted    = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StShift;
          shift_d   = load_data;
          bit_cnt_d = CntMax;
        end
      end
      StShift: begin
        if (bit_cnt_q != '0) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q - CntW'(1);
        end else if (!NoGap) begin
          state_d   = StGap;
          shift_d   = '0;
          gap_cnt_d = GapMax;
        end else if (accept) begin
          shift_d   = load_data;
          bit_cnt_d = CntMax;
        end else begin
          state_d   = StIdle;
          shift_d   = '0;
        end
      end
      StGap: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Outputs decode straight from flops, so they follow reset immediately.
  assign out_valid = (state_q == StShift);
  assign out_bit   = out_valid ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_BIT;
  assign busy      = (state_q != StIdle);
  assign word_done = last_bit;

endmodule
